rs_232_rx_param: RTL

Parametrised RS-232 receive block: a second-generation serial receiver with configurable clock/baud ratio, data width, parity and stop bits. It adds mid-bit sampling with start-bit glitch rejection, per-byte framing and parity error flags, and a small first-word-fall-through receive FIFO with an overrun flag. It sits between the board's RS-232 input pin and downstream byte consumers (command decoders, display logic). It runs in the single system clock domain.

---
 rtl/rs_232_rx_param.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/rs_232_rx_param.sv
// rs_232_rx_param: parametrised RS-232 receiver with mid-bit sampling, start-glitch rejection and a FWFT receive FIFO.
// Latency: push on the last stop sample (t0 + HALF + (DATA_BITS+P+STOP_BITS)*CPB); head/flags visible the cycle after.
// Backpressure: none toward the line; a byte finishing while the FIFO is full and not being popped is dropped and sets overrun.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   rs_232              serial line (idle high, LSB first), synchronized internally
//   rd_en               pop the FIFO head (ignored when empty)
//   ovr_clr             clear the sticky overrun flag (a same-cycle set wins)
//   q, data_ready       FIFO head data (0 when empty), FIFO not empty
//   frame_err           framing-error flag of the head entry
//   parity_err          parity-error flag of the head entry
//   overrun             sticky: a completed byte was dropped because the FIFO was full
module rs_232_rx_param #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rs_232,
  input  logic                 rd_en,
  input  logic                 ovr_clr,
  output logic [DATA_BITS-1:0] q,
  output logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int FW   = DATA_BITS + 2;        // {data, frame_err, parity_err}
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- synchronizer ----------------
  // Both stages reset high so reset release looks like an idle line.
  logic sync_ff1, rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1 <= 1'b1;
      rx_s     <= 1'b1;
    end else begin
      sync_ff1 <= rs_232;
      rx_s     <= sync_ff1;
    end
  end

  // ---------------- receive FSM ----------------
  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_r;
  logic                 perr_r;
  // armed: the line has been seen high since the last start; a start needs a
  // high-to-low transition, so a line held low after reset never starts a frame.
  logic                 armed;

  logic baud_done, last_stop, ferr_now;

  assign baud_done = (baud_cnt == CW'(CPB - 1));
  assign last_stop = (state == S_STOP) && baud_done && (bit_cnt == 4'(STOP_BITS - 1));
  assign ferr_now  = ferr_r | ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      ferr_r   <= 1'b0;
      perr_r   <= 1'b0;
      armed    <= 1'b0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          ferr_r   <= 1'b0;
          perr_r   <= 1'b0;
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (baud_cnt == CW'(HALF - 1)) begin
            baud_cnt <= '0;
            if (rx_s) begin
              // Line back high at mid start bit: glitch, drop it.
              state <= S_IDLE;
              armed <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= S_STOP;
            perr_r   <= (PARITY == 1) ? ~(^{shreg, rx_s}) : (^{shreg, rx_s});
          end
        end
        S_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            ferr_r   <= ferr_now;
            if (last_stop) begin
              // Byte is pushed this cycle; a high stop sample arms the next start.
              state   <= S_IDLE;
              bit_cnt <= '0;
              armed   <= rx_s;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- receive FIFO (first-word fall-through) ----------------
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full, do_pop, do_push, drop;
  logic [FW-1:0] push_dat, head_dat;

  assign push_dat  = {shreg, ferr_now, perr_r};
  assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop    = rd_en && (count != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_push   = last_stop && (!fifo_full || do_pop);
  assign drop      = last_stop && !do_push;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  assign head_dat   = mem[rd_ptr];
  assign data_ready = (count != '0);
  assign q          = data_ready ? head_dat[FW-1:2] : '0;
  assign frame_err  = data_ready & head_dat[1];
  assign parity_err = data_ready & head_dat[0];

endmodule
